// File: rtl/vote_display_scheduler.sv
// vote_display_scheduler
// Results-mode display controller: steps through the per-candidate vote
// counters, converts each to three BCD digits with a serial double-dabble
// engine and presents candidate id + hundreds/tens/ones nibbles for the
// 7-segment bank. Counts above 999 saturate to 999 and raise ovf_o.
// Each candidate stays on display for DWELL cycles, or less if next_i pulses.

module vote_display_scheduler #(
   parameter int N_CAND  = 4,
   parameter int COUNT_W = 10,
   parameter int DWELL   = 50_000_000
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        en,
   input  logic                        next_i,
   input  logic [N_CAND*COUNT_W-1:0]   counts_i,
   output logic [$clog2(N_CAND)-1:0]   sel_o,
   output logic [3:0]                  dig_cand_o,
   output logic [3:0]                  dig_hund_o,
   output logic [3:0]                  dig_tens_o,
   output logic [3:0]                  dig_ones_o,
   output logic                        valid_o,
   output logic                        busy_o,
   output logic                        ovf_o
);

   localparam int SEL_W = $clog2(N_CAND);
   localparam int DW_W  = $clog2(DWELL);
   localparam int BC_W  = $clog2(COUNT_W + 1);

   localparam logic [31:0] MAX_SHOWN = 32'd999;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_CONV = 2'd2;
   localparam logic [1:0] S_SHOW = 2'd3;

   logic [1:0]         state;
   logic [COUNT_W-1:0] bin;        // binary value being shifted out MSB first
   logic [11:0]        bcd;        // hundreds/tens/ones accumulating
   logic [BC_W-1:0]    bit_cnt;    // shifts completed in this conversion
   logic               ovf_pend;   // snapshot was saturated, shown at publish
   logic [DW_W-1:0]    dwell;
   logic [COUNT_W-1:0] cand_count;
   logic [7:0]         bcd_lo_adj;

   // Double-dabble correction: a digit of 5 or more would carry wrongly
   // when doubled, so bias it by 3 before the shift.
   function automatic logic [3:0] dabble(input logic [3:0] nib);
      return (nib >= 4'd5) ? nib + 4'd3 : nib;
   endfunction

   assign busy_o = (state == S_LOAD) || (state == S_CONV);

   // Only tens and ones need the correction: the loaded value is at most 999,
   // so the hundreds digit is at most 4 before every shift and never adjusts.
   assign bcd_lo_adj = {dabble(bcd[7:4]), dabble(bcd[3:0])};

   // Select the counter of the candidate currently addressed by sel_o.
   // NOTE: always_comb assigns a default first so no path leaves the output
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      cand_count = '0;
      for (int k = 0; k < N_CAND; k++) begin
         if (sel_o == SEL_W'(k)) cand_count = counts_i[k*COUNT_W +: COUNT_W];
      end
   end

   // Scheduler FSM, conversion datapath and registered display outputs.
   // NOTE: all state here uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n || !en) begin
         state      <= S_IDLE;
         sel_o      <= '0;
         dig_cand_o <= 4'd0;
         dig_hund_o <= 4'd0;
         dig_tens_o <= 4'd0;
         dig_ones_o <= 4'd0;
         valid_o    <= 1'b0;
         ovf_o      <= 1'b0;
         ovf_pend   <= 1'b0;
         dwell      <= '0;
         bin        <= '0;
         bcd        <= '0;
         bit_cnt    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               sel_o <= '0;
               state <= S_LOAD;
            end
            S_LOAD: begin
               if (32'(cand_count) > MAX_SHOWN) begin
                  bin      <= COUNT_W'(MAX_SHOWN);
                  ovf_pend <= 1'b1;
               end else begin
                  bin      <= cand_count;
                  ovf_pend <= 1'b0;
               end
               bcd     <= '0;
               bit_cnt <= '0;
               state   <= S_CONV;
            end
            S_CONV: begin
               if (bit_cnt == BC_W'(COUNT_W)) begin
                  dig_hund_o <= bcd[11:8];
                  dig_tens_o <= bcd[7:4];
                  dig_ones_o <= bcd[3:0];
                  dig_cand_o <= 4'(sel_o) + 4'd1;
                  ovf_o      <= ovf_pend;
                  valid_o    <= 1'b1;
                  dwell      <= '0;
                  state      <= S_SHOW;
               end else begin
                  bcd     <= {bcd[10:8], bcd_lo_adj, bin[COUNT_W-1]};
                  bin     <= {bin[COUNT_W-2:0], 1'b0};
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            S_SHOW: begin
               if (dwell == DW_W'(DWELL - 1) || next_i) begin
                  sel_o <= (sel_o == SEL_W'(N_CAND - 1)) ? '0 : sel_o + 1'b1;
                  state <= S_LOAD;
               end else begin
                  dwell <= dwell + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
